// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and iterative MUL/MULHU/DIVU/REMU sharing one adder
module alu_seq #(
    parameter int WIDTH     = 32,
    parameter bit ENABLE_MD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             illegal,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    state_t             state;
    logic [SHW-1:0]     cnt;
    logic               hi;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_next;
    logic [WIDTH:0]     add_a, add_b, r_sh;
    logic [WIDTH+1:0]   sum;
    logic               ge;
    logic [WIDTH-1:0]   r, res_md;
    logic               ill, is_mul, is_div, accept;
    logic [SHW-1:0]     sh;
    assign sh       = operand2[SHW-1:0];
    assign is_mul   = ENABLE_MD && operation[3:1] == 3'b101;
    assign is_div   = ENABLE_MD && (operation == 4'b1100 || operation == 4'b1110) && operand2 != '0;
    assign in_ready = rst_n && state == S_IDLE && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = state != S_IDLE;
    always_comb begin
        r   = '0;
        ill = 1'b0;
        case (operation)
            4'b0000: r = operand1 & operand2;
            4'b0001: r = operand1 | operand2;
            4'b0010: r = operand1 + operand2;
            4'b0011: r = operand1 ^ operand2;
            4'b0100: r = operand1 << sh;
            4'b0101: r = operand1 >> sh;
            4'b1101: r = WIDTH'($signed(operand1) >>> sh);
            4'b0110: r = operand1 - operand2;
            4'b0111: r = operand1 - operand2;
            4'b1000: r = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            4'b1001: r = {{(WIDTH-1){1'b0}}, operand1 < operand2};
            // only division by zero reaches these two arms when MD is enabled
            4'b1100: begin r = ENABLE_MD ? '1 : '0; ill = !ENABLE_MD; end
            4'b1110: begin r = ENABLE_MD ? operand1 : '0; ill = !ENABLE_MD; end
            default: ill = 1'b1;
        endcase
    end
    // one shared adder: shift-add multiply or restoring-divide trial subtraction
    always_comb begin
        r_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        add_a  = state == S_DIV ? r_sh : {1'b0, p[2*WIDTH-1:WIDTH]};
        add_b  = state == S_DIV ? ~{1'b0, a} : (p[0] ? {1'b0, a} : '0);
        sum    = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, state == S_DIV};
        ge     = sum[WIDTH+1];
        p_next = state == S_DIV ? {ge ? sum[WIDTH-1:0] : r_sh[WIDTH-1:0], p[WIDTH-2:0], ge}
                                : {sum[WIDTH:0], p[WIDTH-1:1]};
        res_md = hi ? p_next[2*WIDTH-1:WIDTH] : p_next[WIDTH-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= 1'b0;
            a         <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            Z         <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (accept && (is_mul || is_div)) begin
                    state <= is_mul ? S_MUL : S_DIV;
                    cnt   <= '0;
                    hi    <= is_mul ? operation[0] : operation[1];
                    a     <= is_mul ? operand1 : operand2;
                    p     <= {{WIDTH{1'b0}}, is_mul ? operand2 : operand1};
                end else if (accept) begin
                    out_valid <= 1'b1;
                    result    <= r;
                    Z         <= r == '0;
                    illegal   <= ill;
                end
            end else begin
                p   <= p_next;
                cnt <= cnt + 1'b1;
                if (cnt == SHW'(WIDTH-1)) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b1;
                    result    <= res_md;
                    Z         <= res_md == '0;
                    illegal   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32, ENABLE_MD=1)
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, Z, illegal, busy;
    logic [31:0] operand1, operand2, result;
    logic [3:0]  operation;
    int          checks = 0;
    int          errors = 0;

    alu_seq #(.WIDTH(32), .ENABLE_MD(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .Z(Z), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        operation = op;
        operand1  = x;
        operand2  = y;
        in_valid  = 1'b1;
        chk("in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sc(input string tag, input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] e, input logic il);
        issue(op, x, y);
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, result, e);
        chk({tag, "_z"}, Z, e == 0);
        chk({tag, "_ill"}, illegal, il);
    endtask

    task automatic md(input string tag, input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] e);
        int n, nb;
        issue(op, x, y);
        chk({tag, "_stall"}, in_ready, 0);
        n  = 1;
        nb = 0;
        while (n < 100) begin
            if (busy) nb++;
            if (out_valid) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_busy"}, nb, 32);
        chk(tag, result, e);
        chk({tag, "_z"}, Z, e == 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        operand1 = '0; operand2 = '0; operation = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_z", Z, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        sc("add", 4'b0010, 5, 7, 12, 0);
        sc("subb", 4'b0111, 9, 9, 0, 0);
        sc("sub", 4'b0110, 3, 5, 32'hFFFF_FFFE, 0);
        sc("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0);
        sc("or", 4'b0001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 0);
        sc("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0);
        sc("sll", 4'b0100, 1, 31, 32'h8000_0000, 0);
        sc("sra", 4'b1101, 32'h8000_0000, 35, 32'hF000_0000, 0);
        sc("srl", 4'b0101, 32'h8000_0000, 35, 32'h1000_0000, 0);
        sc("slt", 4'b1000, 32'hFFFF_FFFF, 1, 1, 0);
        sc("sltu", 4'b1001, 32'hFFFF_FFFF, 1, 0, 0);
        sc("divz", 4'b1100, 5, 0, 32'hFFFF_FFFF, 0);
        sc("remz", 4'b1110, 5, 0, 5, 0);
        sc("add_wrap", 4'b0010, 32'hFFFF_FFFF, 1, 0, 0);

        @(negedge clk);
        operation = 4'b0010;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            operand1 = i;
            operand2 = 100;
            @(posedge clk);
            #1;
            chk("b2b_valid", out_valid, 1);
            chk("b2b", result, i + 100);
            @(negedge clk);
        end
        out_ready = 1'b0;
        operand1  = 1;
        operand2  = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("hold", result, 109);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain", result, 2);
        chk("drain_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drained", out_valid, 0);

        md("mul", 4'b1010, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        md("mulhu", 4'b1011, 32'hFFFF_FFFF, 2, 1);
        md("mulhu2", 4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);
        md("divu", 4'b1100, 100, 7, 14);
        md("remu", 4'b1110, 100, 7, 2);
        md("divu_big", 4'b1100, 32'hFFFF_FFFF, 32'h8000_0001, 1);

        issue(4'b1010, 3, 5);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", in_ready, 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no_partial", out_valid, 0);
        sc("add11", 4'b0010, 1, 1, 2, 0);
        sc("ill", 4'b1111, 7, 9, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
